// File: rtl/scan_digit_if.sv
// Digit-buffer bus: PS/2 byte strobe and clear in, digit buffer status out.
// The master drives scan bytes and clear; the slave is the buffer.
interface scan_digit_if #(
  parameter int DIGITS = 4
);
  logic [7:0]          scan_code_in;
  logic                scan_valid_in;
  logic                clear_in;
  logic [4*DIGITS-1:0] digits_out;
  logic [3:0]          count_out;
  logic                full_out;
  logic                digit_valid_out;
  logic                error_out;

  modport master (
    output scan_code_in, scan_valid_in, clear_in,
    input  digits_out, count_out, full_out, digit_valid_out, error_out
  );

  modport slave (
    input  scan_code_in, scan_valid_in, clear_in,
    output digits_out, count_out, full_out, digit_valid_out, error_out
  );
endinterface

// File: rtl/scan_digit_buffer.sv
// PS/2 keypad digit buffer: decodes make codes into a shift buffer of nibbles,
// skips break/extended sequences, and supports backspace and clear.
//
// state   | meaning
// IDLE    | no prefix pending, next byte is a make code or a prefix
// BRK     | F0 seen, next byte is a key release and is dropped
// EXT     | E0 seen, next byte is an extended key (dropped) or F0
// EXT_BRK | E0 F0 seen, next byte is an extended release and is dropped
module scan_digit_buffer #(
  parameter int DIGITS   = 4,
  parameter int HEX_MODE = 0
) (
  input logic          clk,
  input logic          rst,
  scan_digit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam logic [3:0] DIG_CNT = 4'(DIGITS);

  state_t              state, state_nxt;
  logic [4*DIGITS-1:0] digits, digits_nxt;
  logic [3:0]          count, count_nxt;
  logic                dv, dv_nxt;
  logic                err, err_nxt;
  logic                key_hit;
  logic [3:0]          key_val;

  always_comb begin
    key_hit = 1'b1;
    key_val = 4'h0;
    case (bus.scan_code_in)
      8'h45: key_val = 4'h0;
      8'h16: key_val = 4'h1;
      8'h1E: key_val = 4'h2;
      8'h26: key_val = 4'h3;
      8'h25: key_val = 4'h4;
      8'h2E: key_val = 4'h5;
      8'h36: key_val = 4'h6;
      8'h3D: key_val = 4'h7;
      8'h3E: key_val = 4'h8;
      8'h46: key_val = 4'h9;
      8'h1C: begin key_val = 4'hA; key_hit = (HEX_MODE != 0); end
      8'h32: begin key_val = 4'hB; key_hit = (HEX_MODE != 0); end
      8'h21: begin key_val = 4'hC; key_hit = (HEX_MODE != 0); end
      8'h23: begin key_val = 4'hD; key_hit = (HEX_MODE != 0); end
      8'h24: begin key_val = 4'hE; key_hit = (HEX_MODE != 0); end
      8'h2B: begin key_val = 4'hF; key_hit = (HEX_MODE != 0); end
      default: key_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    digits_nxt = digits;
    count_nxt  = count;
    dv_nxt     = 1'b0;
    err_nxt    = 1'b0;
    if (bus.clear_in) begin
      state_nxt  = IDLE;
      digits_nxt = '1;
      count_nxt  = 4'd0;
    end else if (bus.scan_valid_in) begin
      case (state)
        IDLE: begin
          if (bus.scan_code_in == 8'hF0) begin
            state_nxt = BRK;
          end else if (bus.scan_code_in == 8'hE0) begin
            state_nxt = EXT;
          end else if (bus.scan_code_in == 8'h00) begin
            state_nxt = IDLE;
          end else if (bus.scan_code_in == 8'h66) begin
            if (count != 4'd0) begin
              digits_nxt = digits >> 4;
              digits_nxt[4*DIGITS-1 -: 4] = 4'hF;
              count_nxt  = count - 4'd1;
            end
          end else if (key_hit) begin
            // Pushing into a full buffer drops the oldest (top) nibble.
            digits_nxt      = digits << 4;
            digits_nxt[3:0] = key_val;
            count_nxt       = (count == DIG_CNT) ? count : count + 4'd1;
            dv_nxt          = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        EXT:     state_nxt = (bus.scan_code_in == 8'hF0) ? EXT_BRK : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      digits <= '1;
      count  <= 4'd0;
      dv     <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      digits <= digits_nxt;
      count  <= count_nxt;
      dv     <= dv_nxt;
      err    <= err_nxt;
    end
  end

  assign bus.digits_out      = digits;
  assign bus.count_out       = count;
  assign bus.full_out        = (count == DIG_CNT);
  assign bus.digit_valid_out = dv;
  assign bus.error_out       = err;

endmodule

// File: doc/scan_digit_buffer.md
SCAN_DIGIT_BUFFER -- requirements
Module: scan_digit_buffer

Interface
REQ-001 Parameter DIGITS, default 4: number of 4-bit digit slots held, legal range 1..8.
REQ-002 Parameter HEX_MODE, default 0: 0 = decimal keys only; 1 = also accept keys A-F.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 scan_code_in  in  8  PS/2 scan code byte; sampled only when scan_valid_in=1.
REQ-006 scan_valid_in  in  1  one-cycle strobe per received byte.
REQ-007 clear_in  in  1  synchronous buffer clear.
REQ-008 digits_out  out  4*DIGITS  digit buffer; nibble 0 = newest digit; empty slots = 4'hF.
REQ-009 count_out  out  4  number of valid digits, 0..DIGITS.
REQ-010 full_out  out  1  high when count_out = DIGITS.
REQ-011 digit_valid_out  out  1  one-cycle pulse, digit accepted.
REQ-012 error_out  out  1  one-cycle pulse, unrecognised make code.

Function
REQ-013 Decode table: 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7, 3E->8, 46->9; with HEX_MODE=1 also 1C->A, 32->B, 21->C, 23->D, 24->E, 2B->F.
REQ-014 Prefix FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
REQ-015 In IDLE: F0 -> BRK; E0 -> EXT; 00 -> ignored, stay in IDLE; 66 (backspace) -> backspace action; decoded key -> push action; any other code -> error_out pulse, no buffer change.
REQ-016 In BRK: the next byte is consumed without action and the FSM returns to IDLE, so no key release produces a digit or error.
REQ-017 In EXT: F0 -> EXT_BRK; any other byte is consumed without action, return to IDLE.
REQ-018 In EXT_BRK: the next byte is consumed without action, return to IDLE.
REQ-019 FSM state and outputs are unchanged in cycles where scan_valid_in=0.
REQ-020 Push: all digits shift up one nibble, the new digit enters nibble 0, count_out increments and saturates at DIGITS.
REQ-021 Push when full: the oldest digit (top nibble) is discarded, count stays DIGITS, digit_valid_out still pulses.
REQ-022 Backspace with count>0: all digits shift down one nibble, top nibble becomes F, count decrements; no pulse on digit_valid_out or error_out.
REQ-023 Backspace with count=0: no change, no pulse.
REQ-024 Repeated make codes without a break code (typematic) each push a digit.
REQ-025 Latency: all outputs reflect a sampled byte on the clock edge that samples it; digit_valid_out and error_out are high for exactly that following cycle.
REQ-026 clear_in=1: all digits become F, count becomes 0, FSM returns to IDLE, scan input ignored that cycle, no pulses.
REQ-027 Priority: rst > clear_in > scan_valid_in.

Reset
REQ-028 On rst=1 at a clock edge: digits_out all F, count_out 0, full_out 0, digit_valid_out 0, error_out 0, FSM IDLE.
REQ-029 A reset asserted while in BRK/EXT/EXT_BRK discards the pending prefix, so the next byte is treated as in IDLE.

Verification
REQ-030 DIGITS=4: bytes 16,F0,16,1E,F0,1E -> digits_out=16'hFF12, count 2, two digit_valid_out pulses, no error.
REQ-031 DIGITS=4: push 1,2,3,4,5 -> digits_out=16'h2345, count 4, full_out=1, five digit_valid_out pulses.
REQ-032 Digits 1,2 then bytes 66 twice then 66 again -> FFF1, then FFFF with count 0, then unchanged with no pulses.
REQ-033 HEX_MODE=0 byte 1C -> error_out pulse, buffer unchanged; HEX_MODE=1 byte 1C -> nibble 0 = A.
REQ-034 E0,16 then E0,F0,16 then 00 -> no buffer change, no pulses; following 45 -> nibble 0 = 0.
REQ-035 F0 followed by clear_in, then 16 -> buffer cleared, then digit 1 pushed (prefix discarded); same with rst instead of clear_in -> identical result.
